// File: rtl/gigatron_vga_capture_if.sv
// Framebuffer write bus driven by gigatron_vga_capture: one strobe per captured pixel,
// with x/y/colour holding their last value while the strobe is low.
interface gigatron_vga_capture_if;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [8:0] wr_y;
    logic [5:0] wr_data;

    modport master (output wr_en, wr_x, wr_y, wr_data);
    modport slave  (input  wr_en, wr_x, wr_y, wr_data);
endinterface

// File: rtl/gigatron_vga_capture.sv
// Recovers pixel x/y from the Gigatron OUT register sync bits and emits one framebuffer
// write per visible pixel. Optional macro GTCAP_DECIMATE_EN keeps only every 4th visible row.
module gigatron_vga_capture #(
    parameter int H_BP     = 12,
    parameter int H_ACTIVE = 160,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [7:0]                    i_out,
    gigatron_vga_capture_if.master        o_wr,
    output logic                          o_frame_done,
    output logic [15:0]                   o_frame_cnt,
    output logic                          o_locked,
    output logic [1:0]                    o_dbg_state
);
    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VBLANK = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] H_BP_W = 8'(H_BP);
    localparam logic [8:0] H_END  = 9'(H_BP + H_ACTIVE);
    localparam logic [9:0] V_BP_W = 10'(V_BP);
    localparam logic [9:0] V_END  = 10'(V_BP + V_ACTIVE);
    localparam logic [7:0] X_LAST = 8'(H_ACTIVE - 1);
`ifdef GTCAP_DECIMATE_EN
    localparam logic [8:0] Y_LAST = 9'(V_ACTIVE / 4 - 1);
`else
    localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);
`endif

    state_t     r_state, w_state_nxt;
    logic [7:0] r_out;
    logic [1:0] r_sync_prev;
    logic [7:0] r_h;
    logic [9:0] r_v;
    logic       r_last_wr;

    logic       w_hs_rise, w_vs_rise;
    logic [7:0] w_h, w_x;
    logic [9:0] w_v, w_vrel;
    logic [8:0] w_y;
    logic       w_vis, w_row_ok, w_wr, w_last;

    // Edges are taken on the registered copy so every decision sees one coherent sample.
    assign w_hs_rise = r_out[6] & ~r_sync_prev[0];
    assign w_vs_rise = r_out[7] & ~r_sync_prev[1];

    always_comb begin
        w_h = 8'd0;
        w_v = r_v;
        if (!w_hs_rise) begin
            w_h = (r_h == 8'hFF) ? r_h : r_h + 8'd1;
        end
        // A coincident hsync rise must not advance v past the vsync restart.
        if (w_vs_rise) begin
            w_v = 10'd0;
        end else if (w_hs_rise && r_v != 10'h3FF) begin
            w_v = r_v + 10'd1;
        end
    end

    always_comb begin
        w_vrel = w_v - V_BP_W;
        w_x    = w_h - H_BP_W;
        w_vis  = (w_h >= H_BP_W) && ({1'b0, w_h} < H_END) &&
                 (w_v >= V_BP_W) && (w_v < V_END);
`ifdef GTCAP_DECIMATE_EN
        w_row_ok = (w_vrel[1:0] == 2'd0);
        w_y      = 9'(w_vrel >> 2);
`else
        w_row_ok = 1'b1;
        w_y      = 9'(w_vrel);
`endif
        w_wr   = w_vis && w_row_ok && !w_vs_rise &&
                 (r_state == S_VBLANK || r_state == S_ACTIVE);
        w_last = w_wr && (w_x == X_LAST) && (w_y == Y_LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SEARCH: if (w_vs_rise) w_state_nxt = S_VBLANK;
            S_VBLANK: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else if (!w_vs_rise && w_v >= V_BP_W) begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (w_vs_rise) begin
                    w_state_nxt = S_VBLANK;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:   if (w_vs_rise) w_state_nxt = S_VBLANK;
            default:  w_state_nxt = S_SEARCH;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state       <= S_SEARCH;
            r_out         <= 8'hC0;
            r_sync_prev   <= 2'b11;
            r_h           <= 8'd0;
            r_v           <= 10'd0;
            r_last_wr     <= 1'b0;
            o_wr.wr_en    <= 1'b0;
            o_wr.wr_x     <= 8'd0;
            o_wr.wr_y     <= 9'd0;
            o_wr.wr_data  <= 6'd0;
            o_frame_done  <= 1'b0;
            o_frame_cnt   <= 16'd0;
            o_locked      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out       <= i_out;
            r_sync_prev <= r_out[7:6];
            r_h         <= w_h;
            r_v         <= w_v;
            o_wr.wr_en  <= w_wr;
            if (w_wr) begin
                o_wr.wr_x    <= w_x;
                o_wr.wr_y    <= w_y;
                o_wr.wr_data <= r_out[5:0];
            end
            // Done trails the final write by one cycle; the counter steps with it.
            r_last_wr    <= w_last;
            o_frame_done <= r_last_wr;
            if (r_last_wr) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end
            if (w_vs_rise) begin
                o_locked <= 1'b1;
            end
        end
    end

    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_gigatron_vga_capture.sv
// Directed bench for gigatron_vga_capture using a reduced frame geometry; expected writes
// come from a line/pixel model of the video the bench itself generates.
module tb_gigatron_vga_capture;
    localparam int H_BP     = 12;
    localparam int H_ACT    = 8;
    localparam int V_BP     = 3;
    localparam int V_ACT    = 8;
    localparam int LINE_LEN = 24;
    localparam int HS_LOW   = 4;
`ifdef GTCAP_DECIMATE_EN
    localparam int ROW_DIV  = 4;
`else
    localparam int ROW_DIV  = 1;
`endif
    localparam int Y_LAST   = V_ACT / ROW_DIV - 1;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vid;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        locked;
    logic [1:0]  dbg_state;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gigatron_vga_capture_if wr_if ();

    gigatron_vga_capture #(
        .H_BP(H_BP), .H_ACTIVE(H_ACT), .V_BP(V_BP), .V_ACTIVE(V_ACT)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_out        (vid),
        .o_wr         (wr_if),
        .o_frame_done (frame_done),
        .o_frame_cnt  (frame_cnt),
        .o_locked     (locked),
        .o_dbg_state  (dbg_state)
    );

    // scoreboard state
    int         total = 0;
    int         bad   = 0;
    logic [22:0] exp_q[$];
    int          exp_t_q[$];
    bit          exp_last_q[$];
    int          m_v        = 0;
    bit          m_cap      = 1'b0;
    bit          m_prev_vs  = 1'b1;
    int          m_done_exp = 0;
    int          done_seen  = 0;
    int          last_wr_cyc = -100;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver: one scan line; vsync level is constant across the line, hsync drops at its tail
    task automatic send_line(input bit vs_n);
        bit         rise;
        bit         hs_n;
        bit         last;
        logic [5:0] col;
        int         x;
        int         y;
        rise = vs_n && !m_prev_vs;
        m_prev_vs = vs_n;
        if (rise) begin
            m_v   = 0;
            m_cap = 1'b1;
        end else if (m_v < 1023) begin
            m_v++;
        end
        for (int h = 0; h < LINE_LEN; h++) begin
            hs_n = (h < LINE_LEN - HS_LOW);
            col  = 6'($urandom_range(0, 63));
            if (m_cap && h >= H_BP && h < H_BP + H_ACT && m_v >= V_BP && m_v < V_BP + V_ACT &&
                ((m_v - V_BP) % ROW_DIV) == 0) begin
                x    = h - H_BP;
                y    = (m_v - V_BP) / ROW_DIV;
                col  = 6'(x ^ (m_v - V_BP));
                last = (x == H_ACT - 1) && (y == Y_LAST);
                exp_q.push_back({8'(x), 9'(y), col});
                exp_t_q.push_back(cyc + 2);
                exp_last_q.push_back(last);
                if (last) begin
                    m_cap = 1'b0;
                    m_done_exp++;
                end
            end
            vid = {vs_n, hs_n, col};
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int n_high);
        send_line(1'b0);
        send_line(1'b0);
        for (int l = 0; l < n_high; l++) send_line(1'b1);
    endtask

    // monitor: every write must land exactly when its pixel is due
    logic [22:0] mon_e;
    int          mon_t;
    bit          mon_l;
    bit          mon_due;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            mon_due = (exp_t_q.size() != 0) && (exp_t_q[0] <= cyc);
            if (wr_if.wr_en || mon_due) begin
                check("wr_en_timing", 32'(wr_if.wr_en), 32'(mon_due));
                if (mon_due) begin
                    mon_e = exp_q.pop_front();
                    mon_t = exp_t_q.pop_front();
                    mon_l = exp_last_q.pop_front();
                    if (wr_if.wr_en) begin
                        check("wr_pixel", 32'({wr_if.wr_x, wr_if.wr_y, wr_if.wr_data}), 32'(mon_e));
                        if (mon_l) last_wr_cyc = mon_t;
                    end
                end
            end
            if (frame_done) begin
                check("done_timing", cyc, last_wr_cyc + 1);
                check("frame_cnt_step", 32'(frame_cnt), done_seen + 1);
                done_seen++;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        vid   = 8'hC0;
        repeat (3) begin
            @(posedge clk);
            #1 vid = 8'($urandom_range(0, 255));
        end
        check("rst_wr_en",   32'(wr_if.wr_en), 0);
        check("rst_wr_x",    32'(wr_if.wr_x), 0);
        check("rst_wr_y",    32'(wr_if.wr_y), 0);
        check("rst_wr_data", 32'(wr_if.wr_data), 0);
        check("rst_done",    32'(frame_done), 0);
        check("rst_cnt",     32'(frame_cnt), 0);
        check("rst_locked",  32'(locked), 0);
        check("rst_state",   32'(dbg_state), 0);

        vid = 8'hC0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_locked", 32'(locked), 0);
        check("idle_state",  32'(dbg_state), 0);

        // full frame from SEARCH; vsync and hsync rise together at its first high line
        send_frame(13);
        check("f1_done_cnt", done_seen, m_done_exp);
        check("f1_frame_cnt", 32'(frame_cnt), 1);
        check("f1_locked",   32'(locked), 1);
        check("f1_state",    32'(dbg_state), 3);
        check("f1_queue",    exp_q.size(), 0);

        // short frame: only rows v=3,4 then the next vsync rise aborts it
        send_frame(5);
        check("ab_state",     32'(dbg_state), 2);
        check("ab_frame_cnt", 32'(frame_cnt), 1);
        send_frame(13);
        check("f2_done_cnt",  done_seen, m_done_exp);
        check("f2_frame_cnt", 32'(frame_cnt), 2);
        check("f2_state",     32'(dbg_state), 3);
        vid = 8'hC0;
        repeat (6) @(posedge clk);
        #1;
        check("f2_queue", exp_q.size(), 0);

        // reset in the middle of an active frame
        send_frame(4);
        check("mid_state", 32'(dbg_state), 2);
        check("mid_queue", exp_q.size(), 0);
        rst_n = 1'b0;
        vid   = 8'hC0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_state",  32'(dbg_state), 0);
        check("mid_rst_cnt",    32'(frame_cnt), 0);
        check("mid_rst_wr_en",  32'(wr_if.wr_en), 0);
        m_cap     = 1'b0;
        m_prev_vs = 1'b1;
        rst_n     = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_locked", 32'(locked), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
